// File: rtl/ir_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ir_ctrl_pkg
// Shared definitions for the instruction-register fetch sequencer.
//   - State encodings for the fetch FSM (FETCH, EXEC, FAULT, HALT).
//   - OPC_HALT: opcode (ir[15:12]) that stops the sequencer when the
//     HALT_EN macro is defined at build time.
// No ports (package).
// ---------------------------------------------------------------------------
package ir_ctrl_pkg;

  localparam logic [1:0] ST_FETCH_ENC = 2'd0;
  localparam logic [1:0] ST_EXEC_ENC  = 2'd1;
  localparam logic [1:0] ST_FAULT_ENC = 2'd2;
  localparam logic [1:0] ST_HALT_ENC  = 2'd3;

  typedef enum logic [1:0] {
    FETCH = ST_FETCH_ENC,
    EXEC  = ST_EXEC_ENC,
    FAULT = ST_FAULT_ENC,
    HALT  = ST_HALT_ENC
  } state_e;

  localparam logic [3:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/fetch_wait_timer.sv
// ---------------------------------------------------------------------------
// fetch_wait_timer
// 8-bit wait counter used while a fetch request is outstanding. It counts
// cycles without an acknowledge and flags the terminal count MAX_WAIT.
// Ports:
//   clk    in   clock, all updates on posedge
//   rst    in   synchronous active-high reset (count -> 0)
//   clr_i  in   clear the count (has priority over en_i)
//   en_i   in   advance the count by one
//   tc_o   out  count has reached MAX_WAIT
// ---------------------------------------------------------------------------
module fetch_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tc_o = (cnt_q == 8'(MAX_WAIT));

  // Hold at the terminal count so the counter can never wrap past it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ir_fetch_ctrl
// Fetch sequencer for the 16-bit instruction register. Owns the PC, runs a
// request/acknowledge handshake to instruction memory, latches the returned
// word into the IR and holds it valid until execute reports completion, then
// increments (already done at fetch) or redirects the PC.
//
// Build option: define HALT_EN to make opcode 4'hF (ir[15:12]) stop the
// sequencer in HALT until reset. Without HALT_EN that opcode is ordinary.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   imem_req       out  fetch request, held until imem_ack
//   imem_addr      out  fetch address (= pc)
//   imem_ack       in   imem_data valid this cycle
//   imem_data      in   instruction word
//   ir_out         out  latched instruction to decode
//   ir_valid       out  ir_out holds an instruction awaiting execution
//   exec_done      in   execute finished the current instruction
//   branch_taken   in   qualifies exec_done: redirect the PC
//   branch_target  in   redirect address
//   pc_out         out  current PC (address of the next fetch)
//   fetch_fault    out  sticky: imem_ack timed out
// ---------------------------------------------------------------------------
module ir_fetch_ctrl
  import ir_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ir_out,
  output logic            ir_valid,
  input  logic            exec_done,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc_out,
  output logic            fetch_fault
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            fault_q, fault_d;

  logic            timer_clr;
  logic            timer_en;
  logic            wait_tc;

  // The wait count only means something while a request is outstanding;
  // any other state, or a successful ack, restarts it from zero.
  assign timer_clr = (state_q != FETCH) || imem_ack;
  assign timer_en  = (state_q == FETCH) && !imem_ack;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (wait_tc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    fault_d = fault_q;

    unique case (state_q)
      FETCH: begin
        // An ack on the timeout cycle still completes the fetch.
        if (imem_ack) begin
          ir_d    = imem_data;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = EXEC;
        end else if (wait_tc) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end

      EXEC: begin
        if (exec_done) begin
          valid_d = 1'b0;
`ifdef HALT_EN
          if (ir_q[15:12] == OPC_HALT) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
            if (branch_taken) begin
              pc_d = branch_target;
            end
          end
`else
          state_d = FETCH;
          if (branch_taken) begin
            pc_d = branch_target;
          end
`endif
        end
      end

      FAULT: begin
        valid_d = 1'b0;
      end

      HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Request is registered: it follows the state we are about to enter.
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= 16'h0000;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign ir_out      = ir_q;
  assign ir_valid    = valid_q;
  assign fetch_fault = fault_q;

endmodule
